// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared definitions for the ALU and its requester arbiter:
//                ALU op codes, arbiter FSM state encoding, width defaults.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int DW_DEFAULT  = 32;
    localparam int OPW_DEFAULT = 4;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_NOR = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
//  Module      : alu
//  Description : Combinational ALU. Unknown op codes produce a zero result.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu
    import alu_pkg::*;
#(
    parameter int DW  = DW_DEFAULT,
    parameter int OPW = OPW_DEFAULT
) (
    input  logic [DW-1:0]  a,
    input  logic [DW-1:0]  b,
    input  logic [OPW-1:0] op,
    output logic [DW-1:0]  result,
    output logic           zero
);

    // Select the operation; the zero flag always reflects the chosen result
    always_comb begin
        result = '0;
        case (op)
            OPW'(ALU_AND): result = a & b;
            OPW'(ALU_OR):  result = a | b;
            OPW'(ALU_ADD): result = a + b;
            OPW'(ALU_XOR): result = a ^ b;
            OPW'(ALU_NOR): result = ~(a | b);
            OPW'(ALU_SUB): result = a - b;
            default:       result = '0;
        endcase
        zero = (result == '0);
    end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter
//  Description : Shares one ALU among NREQ requesters. Round-robin grant in
//                IDLE, one execute cycle, then the response is held in DONE
//                until the consumer takes it.
//                Optional macro ALU_ARB_STATS_EN adds op/grant counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int DW   = DW_DEFAULT,
    parameter int OPW  = OPW_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*DW-1:0]  req_a,
    input  logic [NREQ*DW-1:0]  req_b,
    input  logic [NREQ*OPW-1:0] req_op,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [NREQ-1:0]     resp_id,
    output logic [DW-1:0]       resp_result,
    output logic                resp_zero,
    output logic                busy
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0]         op_count,
    output logic [NREQ*16-1:0]  grant_count
`endif
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t      state;
    logic [PW-1:0]   rr_ptr;
    logic [DW-1:0]   op_a;
    logic [DW-1:0]   op_b;
    logic [OPW-1:0]  op_code;
    logic [NREQ-1:0] op_id;
    logic [NREQ-1:0] grant;
    logic [PW-1:0]   win_idx;
    logic [DW-1:0]   alu_result;
    logic            alu_zero;

    // First valid requester at or after the pointer, wrapping; one-hot result
    function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                                input logic [PW-1:0]   ptr);
        logic [NREQ-1:0] g;
        logic            found;
        int              idx;
        g     = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && valid[idx]) begin
                g[idx] = 1'b1;
                found  = 1'b1;
            end
        end
        return g;
    endfunction

    // Binary index of a one-hot vector
    function automatic logic [PW-1:0] onehot_idx(input logic [NREQ-1:0] g);
        logic [PW-1:0] idx;
        idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (g[i]) idx = PW'(i);
        end
        return idx;
    endfunction

    // Grant is only offered while idle; nothing is queued in EXEC/DONE
    always_comb begin
        grant     = rr_pick(req_valid, rr_ptr);
        win_idx   = onehot_idx(grant);
        req_ready = (state == ST_IDLE) ? grant : '0;
        busy      = (state != ST_IDLE);
    end

    alu #(
        .DW  (DW),
        .OPW (OPW)
    ) u_alu (
        .a      (op_a),
        .b      (op_b),
        .op     (op_code),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // Arbiter FSM: accept and latch operands, execute, hold response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            op_a        <= '0;
            op_b        <= '0;
            op_code     <= '0;
            op_id       <= '0;
            resp_valid  <= 1'b0;
            resp_id     <= '0;
            resp_result <= '0;
            resp_zero   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|grant) begin
                        op_a    <= req_a[win_idx*DW +: DW];
                        op_b    <= req_b[win_idx*DW +: DW];
                        op_code <= req_op[win_idx*OPW +: OPW];
                        op_id   <= grant;
                        rr_ptr  <= (int'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
                        state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    resp_result <= alu_result;
                    resp_zero   <= alu_zero;
                    resp_id     <= op_id;
                    resp_valid  <= 1'b1;
                    state       <= ST_DONE;
                end
                ST_DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    // Completed responses, wrapping at 16 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count <= '0;
        end else if (state == ST_DONE && resp_ready) begin
            op_count <= op_count + 16'd1;
        end
    end

    for (genvar i = 0; i < NREQ; i++) begin : g_grant_cnt
        // Accepts per requester, wrapping at 16 bits
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                grant_count[i*16 +: 16] <= '0;
            end else if (state == ST_IDLE && grant[i]) begin
                grant_count[i*16 +: 16] <= grant_count[i*16 +: 16] + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_arbiter
//  Description : Self-checking bench for alu_arbiter with a behavioural
//                round-robin / ALU reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int NREQ = 2;
    localparam int DW   = 32;
    localparam int OPW  = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*DW-1:0]  req_a;
    logic [NREQ*DW-1:0]  req_b;
    logic [NREQ*OPW-1:0] req_op;
    logic                resp_valid;
    logic                resp_ready;
    logic [NREQ-1:0]     resp_id;
    logic [DW-1:0]       resp_result;
    logic                resp_zero;
    logic                busy;
`ifdef ALU_ARB_STATS_EN
    logic [15:0]         op_count;
    logic [NREQ*16-1:0]  grant_count;
    int                  exp_ops;
    int                  exp_grants [NREQ];
`endif

    int checks = 0;
    int fails  = 0;
    int model_ptr = 0;

    always #5 clk = ~clk;

    alu_arbiter #(
        .NREQ (NREQ),
        .DW   (DW),
        .OPW  (OPW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_op      (req_op),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .resp_zero   (resp_zero),
        .busy        (busy)
`ifdef ALU_ARB_STATS_EN
        ,
        .op_count    (op_count),
        .grant_count (grant_count)
`endif
    );

    function automatic logic [DW-1:0] model_alu(input logic [DW-1:0] a,
                                                input logic [DW-1:0] b,
                                                input logic [OPW-1:0] op);
        case (op)
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_ADD: return a + b;
            ALU_XOR: return a ^ b;
            ALU_NOR: return ~(a | b);
            ALU_SUB: return a - b;
            default: return '0;
        endcase
    endfunction

    function automatic int model_pick(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [DW-1:0] a,
                           input logic [DW-1:0] b, input logic [OPW-1:0] op);
        req_a[i*DW +: DW]    = a;
        req_b[i*DW +: DW]    = b;
        req_op[i*OPW +: OPW] = op;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        model_ptr = 0;
`ifdef ALU_ARB_STATS_EN
        exp_ops = 0;
        for (int i = 0; i < NREQ; i++) exp_grants[i] = 0;
`endif
    endtask

    // One full transaction from IDLE; hold = cycles resp_ready stays low in DONE
    task automatic run_op(input logic [NREQ-1:0] v, input int hold, input string name);
        int              w;
        logic [NREQ-1:0] eid;
        logic [DW-1:0]   er;
        req_valid  = v;
        resp_ready = (hold == 0);
        #1;
        w   = model_pick(v, model_ptr);
        eid = NREQ'(1) << w;
        er  = model_alu(req_a[w*DW +: DW], req_b[w*DW +: DW], req_op[w*OPW +: OPW]);
        checks++;
        if (req_ready !== eid || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s grant: req_ready=%b busy=%b, expected req_ready=%b busy=0",
                     name, req_ready, busy, eid);
        end
        tick();
        req_valid = '0;
        model_ptr = (w + 1) % NREQ;
`ifdef ALU_ARB_STATS_EN
        exp_grants[w]++;
`endif
        #1;
        checks++;
        if (req_ready !== '0 || resp_valid !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL %s exec: req_ready=%b resp_valid=%b busy=%b, expected 0/0/1",
                     name, req_ready, resp_valid, busy);
        end
        tick();
        for (int i = 0; i <= hold; i++) begin
            req_valid = v;
            #1;
            checks++;
            if ({resp_valid, resp_id, resp_zero, resp_result} !== {1'b1, eid, (er == '0), er}) begin
                fails++;
                $display("FAIL %s resp[%0d]: valid=%b id=%b zero=%b result=%h, expected 1 %b %b %h",
                         name, i, resp_valid, resp_id, resp_zero, resp_result, eid, (er == '0), er);
            end
            checks++;
            if (req_ready !== '0 || busy !== 1'b1) begin
                fails++;
                $display("FAIL %s done_hold[%0d]: req_ready=%b busy=%b, expected 0 and 1",
                         name, i, req_ready, busy);
            end
            if (i == hold) resp_ready = 1'b1;
            tick();
        end
        req_valid = '0;
`ifdef ALU_ARB_STATS_EN
        exp_ops++;
`endif
        #1;
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s release: resp_valid=%b busy=%b, expected 0 and 0",
                     name, resp_valid, busy);
        end
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        req_valid  = '0;
        resp_ready = 1'b0;
        req_a      = '0;
        req_b      = '0;
        req_op     = '0;
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_id, resp_result, resp_zero, busy} !== '0) begin
            fails++;
            $display("FAIL reset: ready=%b valid=%b id=%b result=%h zero=%b busy=%b, expected all 0",
                     req_ready, resp_valid, resp_id, resp_result, resp_zero, busy);
        end
        tick();
        tick();
        rst = 1'b0;
        model_reset();
        tick();
    endtask

    task automatic test_sub_zero();
        set_req(0, 32'h0000ABCD, 32'h0000ABCD, ALU_SUB);
        run_op(2'b01, 0, "sub_zero");
    endtask

    task automatic test_round_robin();
        set_req(0, 32'd1, 32'd2, ALU_ADD);
        set_req(1, 32'd10, 32'd20, ALU_ADD);
        for (int i = 0; i < 4; i++) run_op(2'b11, 0, "round_robin");
    endtask

    task automatic test_backpressure();
        set_req(1, 32'h1234_5678, 32'h0F0F_0F0F, ALU_XOR);
        run_op(2'b10, 5, "backpressure");
    endtask

    task automatic test_logic_ops();
        set_req(0, 32'h00000C0C, 32'h0000ABCD, ALU_AND);
        run_op(2'b01, 0, "and_op");
        set_req(0, 32'h00000C0C, 32'h0000ABCD, ALU_OR);
        run_op(2'b01, 1, "or_op");
    endtask

    task automatic test_idle();
        req_valid  = '0;
        resp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (req_ready !== '0 || resp_valid !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL idle[%0d]: req_ready=%b resp_valid=%b busy=%b, expected 0/0/0",
                         i, req_ready, resp_valid, busy);
            end
            tick();
        end
        resp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        set_req(0, 32'h0000_00FF, 32'h0000_0F00, ALU_OR);
        set_req(1, 32'h0000_0005, 32'h0000_0003, ALU_SUB);
        req_valid  = 2'b01;
        resp_ready = 1'b0;
        tick();
        req_valid = '0;
        rst       = 1'b1;
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_id, resp_result, resp_zero, busy} !== '0) begin
            fails++;
            $display("FAIL reset_mid_op: ready=%b valid=%b id=%b result=%h zero=%b busy=%b, expected all 0",
                     req_ready, resp_valid, resp_id, resp_result, resp_zero, busy);
        end
        tick();
        rst = 1'b0;
        model_reset();
        resp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (resp_valid !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL reset_no_resp[%0d]: resp_valid=%b busy=%b, expected 0 and 0",
                         i, resp_valid, busy);
            end
        end
        run_op(2'b11, 0, "post_reset_grant");
    endtask

    task automatic test_random();
        logic [OPW-1:0] ops [6];
        logic [DW-1:0]  a;
        ops[0] = ALU_AND; ops[1] = ALU_OR;  ops[2] = ALU_ADD;
        ops[3] = ALU_XOR; ops[4] = ALU_NOR; ops[5] = ALU_SUB;
        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                a = $urandom;
                set_req(i, a, ($urandom_range(0, 3) == 0) ? a : DW'($urandom),
                        ops[$urandom_range(0, 5)]);
            end
            run_op(NREQ'($urandom_range(1, (1 << NREQ) - 1)), $urandom_range(0, 2), "random");
        end
    endtask

`ifdef ALU_ARB_STATS_EN
    task automatic test_stats();
        test_reset();
        set_req(0, 32'd7, 32'd7, ALU_ADD);
        set_req(1, 32'd3, 32'd9, ALU_SUB);
        for (int i = 0; i < 3; i++) run_op(2'b10, 0, "stats_req1");
        for (int i = 0; i < 2; i++) run_op(2'b01, 0, "stats_req0");
        checks++;
        if (op_count !== 16'(exp_ops) || exp_ops != 5) begin
            fails++;
            $display("FAIL stats op_count: got %0d, expected %0d", op_count, exp_ops);
        end
        checks++;
        if (grant_count !== {16'(exp_grants[1]), 16'(exp_grants[0])} ||
            grant_count !== {16'd3, 16'd2}) begin
            fails++;
            $display("FAIL stats grant_count: got %h, expected %h", grant_count,
                     {16'(exp_grants[1]), 16'(exp_grants[0])});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_sub_zero();
        test_reset();
        test_round_robin();
        test_backpressure();
        test_idle();
        test_logic_ops();
        test_reset_mid_op();
        test_random();
`ifdef ALU_ARB_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
